uart_duplex: RTL

//  Parametrised full-duplex UART (8N1 default) for the icestick designs. Independent RX and TX

---
 rtl/uart_duplex_pkg.sv | 33 +++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_duplex.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_duplex_pkg.sv
// Shared state encodings and parameter helpers for the uart_duplex block.
package uart_duplex_pkg;

  typedef enum logic [2:0] {
    RxIdle   = 3'd0,
    RxStart  = 3'd1,
    RxData   = 3'd2,
    RxParity = 3'd3,
    RxStop   = 3'd4
  } rx_state_e;

  typedef enum logic [2:0] {
    TxIdle   = 3'd0,
    TxStart  = 3'd1,
    TxData   = 3'd2,
    TxParity = 3'd3,
    TxStop   = 3'd4
  } tx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic bit data_bits_legal(input int unsigned n);
    return (n >= 5) && (n <= 9);
  endfunction

  function automatic bit stop_bits_legal(input int unsigned n);
    return (n == 1) || (n == 2);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle timer: counts 0..CLKS_PER_BIT-1 and wraps; held at 0 while clear is high.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic half_tick,
  output logic bit_tick
);

  localparam int unsigned W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [W-1:0] LastCnt = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HalfCnt = W'(CLKS_PER_BIT / 2);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || bit_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bit_tick  = (cnt_q == LastCnt);
  assign half_tick = (cnt_q == HalfCnt);

endmodule

// File: rtl/uart_duplex.sv
// Full-duplex UART with valid/ready byte interfaces, mid-bit RX sampling and error pulses.
// Optional parity bit on both paths when UART_PARITY_EN is defined.
module uart_duplex
  import uart_duplex_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_parity_err
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

`ifdef UART_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  if (!data_bits_legal(DATA_BITS)) begin : g_bad_data_bits
    $error("uart_duplex: DATA_BITS must be 5..9");
  end
  if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
    $error("uart_duplex: STOP_BITS must be 1 or 2");
  end

  // ---------------- RX path ----------------
  logic                 rx_meta, rx_s;
  rx_state_e            rx_state;
  logic [DATA_BITS-1:0] rx_shift;
  logic [3:0]           rx_cnt;
  logic                 rx_par_bad;
  logic                 rx_clear, rx_half, rx_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Timer restarts at the mid-start sample so data samples land mid-bit.
  assign rx_clear = (rx_state == RxIdle) || ((rx_state == RxStart) && rx_half);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (rx_clear),
    .half_tick(rx_half),
    .bit_tick (rx_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= RxIdle;
      rx_shift      <= '0;
      rx_cnt        <= '0;
      rx_par_bad    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_parity_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (rx_state)
        RxIdle: begin
          if (!rx_s) begin
            rx_state <= RxStart;
          end
        end
        RxStart: begin
          if (rx_half) begin
            if (rx_s) begin
              rx_state <= RxIdle;
            end else begin
              rx_state   <= RxData;
              rx_cnt     <= '0;
              rx_par_bad <= 1'b0;
            end
          end
        end
        RxData: begin
          if (rx_bit) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_cnt == 4'(DATA_BITS - 1)) begin
              rx_state <= ParityEn ? RxParity : RxStop;
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
          end
        end
        RxParity: begin
          if (rx_bit) begin
            rx_par_bad <= ((^rx_shift) ^ rx_s) != 1'(PARITY_ODD);
            rx_state   <= RxStop;
          end
        end
        RxStop: begin
          if (rx_bit) begin
            rx_state <= RxIdle;
            if (!rx_s) begin
              rx_frame_err <= 1'b1;
            end else if (rx_par_bad) begin
              rx_parity_err <= 1'b1;
            end else if (rx_valid && !rx_ready) begin
              rx_overrun <= 1'b1;
            end else begin
              // Overrides the accept-clear above when a byte lands on the accept cycle.
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

  // ---------------- TX path ----------------
  tx_state_e            tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic [3:0]           tx_cnt;
  logic                 tx_par;
  logic                 tx_stop_cnt;
  logic                 tx_clear, tx_bit, tx_half_unused;

  assign tx_clear = (tx_state == TxIdle);
  assign tx_ready = (tx_state == TxIdle);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tx_clear),
    .half_tick(tx_half_unused),
    .bit_tick (tx_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TxIdle;
      tx          <= 1'b1;
      tx_shift    <= '0;
      tx_cnt      <= '0;
      tx_par      <= 1'b0;
      tx_stop_cnt <= 1'b0;
    end else begin
      case (tx_state)
        TxIdle: begin
          tx <= 1'b1;
          if (tx_valid) begin
            tx_shift <= tx_data;
            tx_par   <= (^tx_data) ^ 1'(PARITY_ODD);
            tx       <= 1'b0;
            tx_state <= TxStart;
          end
        end
        TxStart: begin
          if (tx_bit) begin
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_cnt   <= '0;
            tx_state <= TxData;
          end
        end
        TxData: begin
          if (tx_bit) begin
            if (tx_cnt == 4'(DATA_BITS - 1)) begin
              tx_stop_cnt <= 1'b0;
              if (ParityEn) begin
                tx       <= tx_par;
                tx_state <= TxParity;
              end else begin
                tx       <= 1'b1;
                tx_state <= TxStop;
              end
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_cnt   <= tx_cnt + 4'd1;
            end
          end
        end
        TxParity: begin
          if (tx_bit) begin
            tx       <= 1'b1;
            tx_state <= TxStop;
          end
        end
        TxStop: begin
          if (tx_bit) begin
            if (tx_stop_cnt == 1'(STOP_BITS - 1)) begin
              tx_state <= TxIdle;
            end else begin
              tx_stop_cnt <= tx_stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_state <= TxIdle;
        end
      endcase
    end
  end

endmodule
